// File: rtl/twos_comp_pkg.sv
// Shared definitions for the two's-complement serial blocks (decoder and negator).
//   state_t       : 2-bit FSM state encoding (IDLE, SHIFT, DONE)
//   cnt_width()   : bit width of a counter that indexes 0..w-1
package twos_comp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of a bit-index counter for a w-bit word; at least one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage : twos_comp_pkg

// File: rtl/serial_negate_cell.sv
// Combinational Mealy bit cell for LSB-first two's-complement negation
// (copy bits up to and including the first 1, invert everything after).
// Ports:
//   b             in   current input bit
//   neg           in   1 = negate this word, 0 = pass bits through
//   seen_one      in   a 1 has already been processed in this word
//   o             out  output bit
//   seen_one_next out  updated seen_one flag for the next bit
module serial_negate_cell (
    input  logic b,
    input  logic neg,
    input  logic seen_one,
    output logic o,
    output logic seen_one_next
);

    always_comb begin
        o             = b ^ (neg & seen_one);
        seen_one_next = seen_one | b;
    end

endmodule : serial_negate_cell

// File: rtl/twos_comp_serial_decoder.sv
// Bit-serial two's-complement to sign-magnitude decoder.
// Accepts one WIDTH-bit word, walks it LSB-first one bit per clock, then
// holds Sign/Mag/Min_neg until the consumer takes them.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   In, in_valid        two's-complement input word and its valid
//   in_ready            high in IDLE: a word can be accepted
//   Sign, Mag           sign bit and unsigned magnitude of the held result
//   Min_neg             held input was the most-negative value
//   out_valid           high in DONE: result is valid
//   out_ready           consumer takes the result
module twos_comp_serial_decoder
    import twos_comp_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] In,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             Sign,
    output logic [WIDTH-1:0] Mag,
    output logic             Min_neg,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned      CW      = cnt_width(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MAG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             seen_one;

    logic             bit_o;
    logic             seen_one_nxt;
    logic [WIDTH-1:0] mag_next;
    logic             accept;
    logic             last_bit;

    serial_negate_cell u_cell (
        .b             (shreg[0]),
        .neg           (Sign),
        .seen_one      (seen_one),
        .o             (bit_o),
        .seen_one_next (seen_one_nxt)
    );

    // Handshake flags decode straight from the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign accept   = in_ready & in_valid;
    assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);
    assign mag_next = {bit_o, Mag[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            cnt      <= '0;
            seen_one <= 1'b0;
            Sign     <= 1'b0;
            Mag      <= '0;
            Min_neg  <= 1'b0;
        end else if (accept) begin
            shreg    <= In;
            Sign     <= In[WIDTH-1];
            cnt      <= '0;
            seen_one <= 1'b0;
            Mag      <= '0;
            Min_neg  <= 1'b0;
        end else if (state == SHIFT) begin
            shreg    <= {1'b0, shreg[WIDTH-1:1]};
            seen_one <= seen_one_nxt;
            Mag      <= mag_next;
            if (last_bit) begin
                // Most-negative input is its own negation: Mag ends as 1 then 0s.
                Min_neg <= Sign & (mag_next == MAG_MIN);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule : twos_comp_serial_decoder

// File: tb/tb_twos_comp_serial_decoder.sv
// Self-checking bench for twos_comp_serial_decoder at WIDTH=4.
module tb_twos_comp_serial_decoder;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] In = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         Sign;
    logic [W-1:0] Mag;
    logic         Min_neg;
    logic         out_valid;
    logic         out_ready = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    twos_comp_serial_decoder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .In        (In),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sign      (Sign),
        .Mag       (Mag),
        .Min_neg   (Min_neg),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: sign is the top bit, magnitude is |value| taken mod 2^W.
    function automatic logic [W-1:0] ref_mag(input logic [W-1:0] w);
        int v;
        v = w[W-1] ? (int'(w) - (1 << W)) : int'(w);
        if (v < 0) v = -v;
        return W'(v % (1 << W));
    endfunction

    task automatic check_result(input string tag, input logic [W-1:0] w);
        check({tag, "_sign"},   Sign,    w[W-1]);
        check({tag, "_mag"},    Mag,     ref_mag(w));
        check({tag, "_minneg"}, Min_neg, (w == (1 << (W-1))));
    endtask

    // Offer w, wait for acceptance, check latency, then wait for the result.
    task automatic send(input string tag, input logic [W-1:0] w);
        int lat;
        int guard;
        guard = 0;
        In = w;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin tick(); guard++; end
        check({tag, "_ready_timeout"}, (guard < 50), 1);
        tick();                       // acceptance edge
        in_valid = 1'b0;
        In = $urandom;                // must be ignored while busy
        check({tag, "_busy"}, in_ready, 1'b0);
        lat = 0;
        while (!out_valid && lat < 20) begin tick(); lat++; end
        check({tag, "_latency"}, lat, W);
    endtask

    // Hold out_ready low for hold cycles (outputs must stay), then handshake.
    task automatic drain(input string tag, input logic [W-1:0] w, input int hold);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_valid"}, out_valid, 1'b1);
            check({tag, "_hold_ready"}, in_ready, 1'b0);
            check_result({tag, "_hold"}, w);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_post_valid"}, out_valid, 1'b0);
        check({tag, "_post_ready"}, in_ready, 1'b1);
    endtask

    task automatic run_word(input string tag, input logic [W-1:0] w, input int hold);
        send(tag, w);
        check_result(tag, w);
        drain(tag, w, hold);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sign",      Sign,      1'b0);
        check("rst_mag",       Mag,       '0);
        check("rst_minneg",    Min_neg,   1'b0);
        rst_n = 1'b1;
        tick();

        // Directed words
        run_word("pos5",   4'b0101, 0);
        run_word("neg5",   4'b1011, 0);
        run_word("neg1",   4'b1111, 0);
        run_word("minneg", 4'b1000, 0);
        run_word("zero",   4'b0000, 0);

        // Backpressure with a second word offered while DONE
        send("bp", 4'b1110);
        check_result("bp", 4'b1110);
        In = 4'b0110;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_ready", in_ready, 1'b0);
            check_result("bp_hold", 4'b1110);
        end
        out_ready = 1'b1;
        tick();                       // output handshake; word not taken here
        out_ready = 1'b0;
        check("bp_idle_ready", in_ready, 1'b1);
        tick();                       // second word accepted now
        in_valid = 1'b0;
        check("bp_second_busy", in_ready, 1'b0);
        begin
            int lat;
            lat = 0;
            while (!out_valid && lat < 20) begin tick(); lat++; end
            check("bp_second_latency", lat, W);
        end
        check_result("bp_second", 4'b0110);
        drain("bp_second", 4'b0110, 0);

        // Reset during SHIFT
        In = 4'b1001;
        in_valid = 1'b1;
        tick();                       // accepted
        in_valid = 1'b0;
        tick();                       // second SHIFT cycle
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_in_ready",  in_ready,  1'b1);
        check("arst_sign",      Sign,      1'b0);
        check("arst_mag",       Mag,       '0);
        check("arst_minneg",    Min_neg,   1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        check("arst_still_idle", out_valid, 1'b0);
        run_word("after_rst", 4'b0011, 1);

        // Exhaustive sweep, random backpressure
        for (int k = 0; k < 16; k++) begin
            run_word($sformatf("sweep%0d", k), W'(k), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_twos_comp_serial_decoder
